// File: rtl/udp_test_pkt_gen.sv
// UDP test-traffic generator: resolves the peer MAC over ARP, then emits sequence-numbered
// UDP payloads of programmable length, pattern and count with a fixed inter-packet gap.
module udp_test_pkt_gen #(
  parameter int unsigned GAP_CNT       = 125_000_000,
  parameter int unsigned ARP_RETRY_CNT = 125_000_000,
  parameter int unsigned ARP_MAX_RETRY = 8,
  parameter int unsigned MAX_LEN       = 1472,
  parameter logic [7:0]  LFSR_SEED     = 8'hFF
) (
  input  logic        rgmii_clk,
  input  logic        rst,
  input  logic        cfg_enable,
  input  logic [1:0]  cfg_mode,
  input  logic [7:0]  cfg_fill,
  input  logic [15:0] cfg_len,
  input  logic [15:0] cfg_pkt_num,
  output logic        app_data_request,
  output logic [15:0] app_data_length,
  input  logic        udp_send_ack,
  output logic        app_data_in_valid,
  output logic [7:0]  app_data_in,
  output logic        arp_req,
  input  logic        arp_found,
  input  logic        mac_not_exist,
  input  logic        mac_send_end,
  output logic        busy,
  output logic        done,
  output logic        arp_fail,
  output logic [31:0] pkt_cnt
);

  localparam logic [31:0] GAP_LAST  = 32'(GAP_CNT - 1);
  localparam logic [31:0] ARP_LAST  = 32'(ARP_RETRY_CNT - 1);
  localparam logic [15:0] LEN_MAX   = 16'(MAX_LEN);
  localparam logic [7:0]  RETRY_MAX = 8'(ARP_MAX_RETRY);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ARP_REQ   = 4'd1,
    ARP_SEND  = 4'd2,
    ARP_WAIT  = 4'd3,
    CHECK_ARP = 4'd4,
    GEN_REQ   = 4'd5,
    WRITE     = 4'd6,
    SEND_WAIT = 4'd7,
    GAP       = 4'd8,
    DONE      = 4'd9
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] timer_r, run_cnt_r, seq_r;
  logic [7:0]  retry_r, lfsr_r, fill_r;
  logic [1:0]  mode_r;
  logic [15:0] len_r, byte_idx_r, idx_nxt_s, len_clamp_s;
  logic        write_nxt_s, lfsr_adv_s;
  logic [7:0]  byte_nxt_s;

  logic        arp_req_r, app_data_request_r, valid_r, busy_r, done_r, arp_fail_r;
  logic [7:0]  data_r;

  // Payload byte k: big-endian sequence number in bytes 0..3, then the selected pattern.
  function automatic logic [7:0] pay_byte(input logic [15:0] k, input logic [31:0] seq,
                                          input logic [1:0] mode, input logic [7:0] fill,
                                          input logic [7:0] lfsr);
    logic [15:0] off;
    logic [7:0]  res;
    off = k - 16'd4;
    if (k < 16'd4) begin
      case (k[1:0])
        2'd0:    res = seq[31:24];
        2'd1:    res = seq[23:16];
        2'd2:    res = seq[15:8];
        default: res = seq[7:0];
      endcase
    end else begin
      case (mode)
        2'd1:    res = fill;
        2'd2:    res = lfsr;
        default: res = off[7:0];
      endcase
    end
    return res;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cfg_enable) state_nxt_s = ARP_REQ;
        else            state_nxt_s = IDLE;
      end
      ARP_REQ: state_nxt_s = ARP_SEND;
      ARP_SEND: begin
        if (mac_send_end) state_nxt_s = ARP_WAIT;
        else              state_nxt_s = ARP_SEND;
      end
      ARP_WAIT: begin
        if (arp_found) begin
          state_nxt_s = CHECK_ARP;
        end else if (timer_r == ARP_LAST) begin
          if (retry_r == RETRY_MAX) state_nxt_s = IDLE;
          else                      state_nxt_s = ARP_REQ;
        end else begin
          state_nxt_s = ARP_WAIT;
        end
      end
      CHECK_ARP: begin
        if (!cfg_enable)        state_nxt_s = IDLE;
        else if (mac_not_exist) state_nxt_s = ARP_REQ;
        else                    state_nxt_s = GEN_REQ;
      end
      GEN_REQ: begin
        if (udp_send_ack) state_nxt_s = WRITE;
        else              state_nxt_s = GEN_REQ;
      end
      WRITE: begin
        if (byte_idx_r == len_r - 16'd1) state_nxt_s = SEND_WAIT;
        else                             state_nxt_s = WRITE;
      end
      SEND_WAIT: begin
        if (mac_send_end) state_nxt_s = GAP;
        else              state_nxt_s = SEND_WAIT;
      end
      GAP: begin
        if (timer_r == GAP_LAST) begin
          if (!cfg_enable)
            state_nxt_s = IDLE;
          else if ((cfg_pkt_num != 16'd0) && (run_cnt_r == {16'd0, cfg_pkt_num}))
            state_nxt_s = DONE;
          else
            state_nxt_s = CHECK_ARP;
        end else begin
          state_nxt_s = GAP;
        end
      end
      DONE: begin
        if (!cfg_enable) state_nxt_s = IDLE;
        else             state_nxt_s = DONE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Length clamp and next payload byte selection.
  always_comb begin
    len_clamp_s = cfg_len;
    if (cfg_len == 16'd0)        len_clamp_s = 16'd1;
    else if (cfg_len > LEN_MAX)  len_clamp_s = LEN_MAX;
    else                         len_clamp_s = cfg_len;

    idx_nxt_s   = 16'd0;
    if (state_r == WRITE) idx_nxt_s = byte_idx_r + 16'd1;
    else                  idx_nxt_s = 16'd0;

    write_nxt_s = (state_nxt_s == WRITE);
    lfsr_adv_s  = write_nxt_s && (idx_nxt_s >= 16'd4) && (mode_r == 2'd2);
    byte_nxt_s  = pay_byte(idx_nxt_s, seq_r, mode_r, fill_r, lfsr_r);
  end

  // State, timers, run/retry/sequence counters and per-packet configuration latches.
  always_ff @(posedge rgmii_clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      timer_r    <= 32'd0;
      run_cnt_r  <= 32'd0;
      seq_r      <= 32'd0;
      retry_r    <= 8'd0;
      arp_fail_r <= 1'b0;
      len_r      <= 16'd0;
      mode_r     <= 2'd0;
      fill_r     <= 8'd0;
      lfsr_r     <= LFSR_SEED;
      byte_idx_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      // The shared timer restarts on every state change.
      if (state_nxt_s != state_r) timer_r <= 32'd0;
      else                        timer_r <= timer_r + 32'd1;

      if (state_r == IDLE && cfg_enable) begin
        retry_r    <= 8'd0;
        run_cnt_r  <= 32'd0;
        arp_fail_r <= 1'b0;
      end else if (state_r == ARP_REQ) begin
        retry_r <= retry_r + 8'd1;
      end else if (state_r == CHECK_ARP && cfg_enable && mac_not_exist) begin
        retry_r <= 8'd0;
      end else if (state_r == ARP_WAIT && state_nxt_s == IDLE) begin
        arp_fail_r <= 1'b1;
      end else if (state_r == SEND_WAIT && mac_send_end) begin
        seq_r     <= seq_r + 32'd1;
        run_cnt_r <= run_cnt_r + 32'd1;
      end else begin
        retry_r <= retry_r;
      end

      if (state_r == CHECK_ARP && state_nxt_s == GEN_REQ) begin
        len_r  <= len_clamp_s;
        mode_r <= cfg_mode;
        fill_r <= cfg_fill;
        lfsr_r <= LFSR_SEED;
      end else if (lfsr_adv_s) begin
        lfsr_r <= lfsr_step(lfsr_r);
      end else begin
        lfsr_r <= lfsr_r;
      end

      if (write_nxt_s) byte_idx_r <= idx_nxt_s;
      else             byte_idx_r <= 16'd0;
    end
  end

  // Registered stack-facing and status outputs, decoded from the next state.
  always_ff @(posedge rgmii_clk or posedge rst) begin
    if (rst) begin
      arp_req_r          <= 1'b0;
      app_data_request_r <= 1'b0;
      valid_r            <= 1'b0;
      data_r             <= 8'd0;
      busy_r             <= 1'b0;
      done_r             <= 1'b0;
    end else begin
      arp_req_r          <= (state_nxt_s == ARP_REQ);
      app_data_request_r <= (state_nxt_s == GEN_REQ);
      valid_r            <= write_nxt_s;
      busy_r             <= (state_nxt_s != IDLE) && (state_nxt_s != DONE);
      done_r             <= (state_nxt_s == DONE);
      if (write_nxt_s) data_r <= byte_nxt_s;
      else             data_r <= 8'd0;
    end
  end

  assign arp_req           = arp_req_r;
  assign app_data_request  = app_data_request_r;
  assign app_data_length   = len_r;
  assign app_data_in_valid = valid_r;
  assign app_data_in       = data_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign arp_fail          = arp_fail_r;
  assign pkt_cnt           = seq_r;

endmodule

// File: tb/tb_udp_test_pkt_gen.sv
// Directed bench for udp_test_pkt_gen: ARP handshake, payload patterns, length clamping,
// ARP retry exhaustion, MAC-not-cached re-ARP and mid-packet reset.
module tb_udp_test_pkt_gen;

  logic        rgmii_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [1:0]  cfg_mode = 2'd0;
  logic [7:0]  cfg_fill = 8'd0;
  logic [15:0] cfg_len = 16'd8;
  logic [15:0] cfg_pkt_num = 16'd2;
  logic        app_data_request;
  logic [15:0] app_data_length;
  logic        udp_send_ack = 1'b0;
  logic        app_data_in_valid;
  logic [7:0]  app_data_in;
  logic        arp_req;
  logic        arp_found = 1'b0;
  logic        mac_not_exist = 1'b0;
  logic        mac_send_end = 1'b0;
  logic        busy;
  logic        done;
  logic        arp_fail;
  logic [31:0] pkt_cnt;

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          arp_cnt = 0;
  int          arp_t[$];
  logic [7:0]  rx_q[$];
  int          a0;

  udp_test_pkt_gen #(
    .GAP_CNT(16), .ARP_RETRY_CNT(32), .ARP_MAX_RETRY(3), .MAX_LEN(1472), .LFSR_SEED(8'hFF)
  ) dut (
    .rgmii_clk(rgmii_clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .cfg_fill(cfg_fill), .cfg_len(cfg_len), .cfg_pkt_num(cfg_pkt_num),
    .app_data_request(app_data_request), .app_data_length(app_data_length),
    .udp_send_ack(udp_send_ack), .app_data_in_valid(app_data_in_valid),
    .app_data_in(app_data_in), .arp_req(arp_req), .arp_found(arp_found),
    .mac_not_exist(mac_not_exist), .mac_send_end(mac_send_end), .busy(busy),
    .done(done), .arp_fail(arp_fail), .pkt_cnt(pkt_cnt)
  );

  always #4 rgmii_clk = ~rgmii_clk;

  always @(posedge rgmii_clk) cyc <= cyc + 1;

  // Record ARP pulses and payload bytes mid-cycle.
  always @(negedge rgmii_clk) begin
    if (arp_req) begin
      arp_cnt = arp_cnt + 1;
      arp_t.push_back(cyc);
    end
    if (app_data_in_valid) rx_q.push_back(app_data_in);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge rgmii_clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig_val(input int sel);
    case (sel)
      0:       return arp_req;
      1:       return app_data_request;
      2:       return done;
      3:       return arp_fail;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int limit, input string tag);
    int n;
    n = 0;
    while (!sig_val(sel) && n < limit) begin
      tick(1);
      n++;
    end
    check(tag, {31'd0, sig_val(sel)}, 32'd1);
  endtask

  task automatic pulse_send_end();
    mac_send_end = 1'b1;
    tick(1);
    mac_send_end = 1'b0;
  endtask

  task automatic do_arp(input logic nx);
    wait_sig(0, 60, "arp_req_seen");
    tick(2);
    pulse_send_end();
    tick(9);
    mac_not_exist = nx;
    arp_found = 1'b1;
    tick(1);
    arp_found = 1'b0;
    tick(1);
    mac_not_exist = 1'b0;
  endtask

  task automatic do_packet(input int len_exp);
    wait_sig(1, 60, "data_request");
    check("app_data_length", {16'd0, app_data_length}, len_exp);
    tick(2);
    check("request_held", {31'd0, app_data_request}, 32'd1);
    udp_send_ack = 1'b1;
    tick(1);
    udp_send_ack = 1'b0;
    tick(len_exp + 2);
    pulse_send_end();
  endtask

  task automatic expect_bytes(input string tag, input logic [127:0] exp_v, input int n);
    logic [7:0] e;
    check({tag, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++) begin
      e = exp_v[8*(n-1-i) +: 8];
      check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, e});
    end
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_arp_req", {31'd0, arp_req}, 32'd0);
    check("rst_request", {31'd0, app_data_request}, 32'd0);
    check("rst_length", {16'd0, app_data_length}, 32'd0);
    check("rst_valid", {31'd0, app_data_in_valid}, 32'd0);
    check("rst_data", {24'd0, app_data_in}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_arp_fail", {31'd0, arp_fail}, 32'd0);
    check("rst_pkt_cnt", pkt_cnt, 32'd0);
    rst = 1'b0;
    tick(2);

    // Incrementing pattern, len 8, two packets
    a0 = arp_cnt;
    rx_q.delete();
    cfg_mode = 2'd0; cfg_len = 16'd8; cfg_pkt_num = 16'd2;
    cfg_enable = 1'b1;
    do_arp(1'b0);
    do_packet(8);
    do_packet(8);
    wait_sig(2, 60, "t1_done");
    check("t1_pkt_cnt", pkt_cnt, 32'd2);
    check("t1_arp_pulses", arp_cnt - a0, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);
    expect_bytes("t1", 128'h0000000000010203_0000000100010203, 16);
    cfg_enable = 1'b0;
    tick(2);
    check("t1_done_clear", {31'd0, done}, 32'd0);

    // PRBS pattern, len 6, reseeded every packet
    rx_q.delete();
    cfg_mode = 2'd2; cfg_len = 16'd6; cfg_pkt_num = 16'd2;
    cfg_enable = 1'b1;
    do_arp(1'b0);
    do_packet(6);
    do_packet(6);
    wait_sig(2, 60, "t2_done");
    expect_bytes("t2", 128'h00000002FFFE_00000003FFFE, 12);
    check("t2_pkt_cnt", pkt_cnt, 32'd4);
    cfg_enable = 1'b0;
    tick(2);

    // Length clamp: 0 -> 1
    rx_q.delete();
    cfg_mode = 2'd0; cfg_len = 16'd0; cfg_pkt_num = 16'd1;
    cfg_enable = 1'b1;
    do_arp(1'b0);
    do_packet(1);
    wait_sig(2, 60, "t4a_done");
    expect_bytes("t4a", 128'h00, 1);
    cfg_enable = 1'b0;
    tick(2);

    // Length clamp: 2000 -> 1472
    rx_q.delete();
    cfg_len = 16'd2000;
    cfg_enable = 1'b1;
    do_arp(1'b0);
    do_packet(1472);
    wait_sig(2, 60, "t4b_done");
    check("t4b_count", rx_q.size(), 32'd1472);
    if (rx_q.size() == 1472) begin
      check("t4b_seq3", {24'd0, rx_q[3]}, 32'h05);
      check("t4b_byte4", {24'd0, rx_q[4]}, 32'h00);
      check("t4b_last", {24'd0, rx_q[1471]}, 32'hBB);
    end
    cfg_enable = 1'b0;
    tick(2);

    // MAC not cached: re-ARP before the request
    a0 = arp_cnt;
    rx_q.delete();
    cfg_mode = 2'd1; cfg_fill = 8'hA5; cfg_len = 16'd5; cfg_pkt_num = 16'd1;
    cfg_enable = 1'b1;
    do_arp(1'b1);
    check("t5_rearp", {31'd0, arp_req}, 32'd1);
    check("t5_no_request", {31'd0, app_data_request}, 32'd0);
    do_arp(1'b0);
    do_packet(5);
    wait_sig(2, 60, "t5_done");
    check("t5_arp_pulses", arp_cnt - a0, 32'd2);
    expect_bytes("t5", 128'h00000006A5, 5);
    cfg_enable = 1'b0;
    tick(2);

    // ARP exhaustion after 3 attempts
    a0 = arp_cnt;
    arp_t.delete();
    cfg_mode = 2'd0; cfg_len = 16'd8; cfg_pkt_num = 16'd1;
    cfg_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_sig(0, 80, "t3_arp_attempt");
      tick(2);
      pulse_send_end();
      if (i == 2) cfg_enable = 1'b0;
    end
    wait_sig(3, 80, "t3_arp_fail");
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_done", {31'd0, done}, 32'd0);
    tick(5);
    check("t3_arp_pulses", arp_cnt - a0, 32'd3);
    check("t3_fail_sticky", {31'd0, arp_fail}, 32'd1);
    check("t3_no_request", {31'd0, app_data_request}, 32'd0);
    if (arp_t.size() >= 2) check("t3_spacing", {31'd0, (arp_t[1] - arp_t[0]) > 32}, 32'd1);

    // Reset during WRITE at byte 5
    cfg_pkt_num = 16'd0;
    cfg_enable = 1'b1;
    do_arp(1'b0);
    check("t6_fail_cleared", {31'd0, arp_fail}, 32'd0);
    wait_sig(1, 60, "t6_request");
    udp_send_ack = 1'b1;
    tick(1);
    udp_send_ack = 1'b0;
    tick(5);
    check("t6_byte5", {24'd0, app_data_in}, 32'h01);
    check("t6_seq_pre", pkt_cnt, 32'd7);
    rst = 1'b1;
    #1;
    check("t6_valid", {31'd0, app_data_in_valid}, 32'd0);
    check("t6_data", {24'd0, app_data_in}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_pkt_cnt", pkt_cnt, 32'd0);
    check("t6_length", {16'd0, app_data_length}, 32'd0);
    tick(2);
    rx_q.delete();
    rst = 1'b0;
    do_arp(1'b0);
    do_packet(8);
    cfg_enable = 1'b0;
    tick(30);
    expect_bytes("t6", 128'h0000000000010203, 8);
    check("t6_pkt_cnt_after", pkt_cnt, 32'd1);
    check("t6_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_test_pkt_gen.md
Name: udp_test_pkt_gen

Overview:
Parametrised UDP test-traffic generator that sits above the UDP/IP/MAC stack (udp_ip_mac_top) on the GMII side, in the rgmii_clk domain.
- Resolves the destination MAC via ARP, then sends UDP packets of run-time-selectable length, payload pattern and count, with a programmable inter-packet gap.
- Each payload is prefixed with a 32-bit sequence number so the far end can detect loss.
- Replaces the fixed-string, fixed-interval test sender.

Parameters:
GAP_CNT, 125_000_000, rgmii_clk cycles between end of one packet and the next request
ARP_RETRY_CNT, 125_000_000, cycles to wait for arp_found before re-issuing ARP
ARP_MAX_RETRY, 8, ARP attempts before giving up (1..255)
MAX_LEN, 1472, upper clamp on payload bytes (1..65535)
LFSR_SEED, 8'hFF, PRBS seed, nonzero

Ports:
rgmii_clk  in  1  sole clock, 125 MHz
rst  in  1  asynchronous, active-high reset
cfg_enable  in  1  level; 1 = run, 0 = stop after current packet
cfg_mode  in  2  payload pattern: 0 incrementing byte, 1 constant fill, 2 PRBS8, 3 reserved (treated as 0)
cfg_fill  in  8  fill byte for mode 1
cfg_len  in  16  requested payload bytes
cfg_pkt_num  in  16  packets per run; 0 = continuous
app_data_request  out  1  to stack: UDP send request
app_data_length  out  16  to stack: payload length of current packet
udp_send_ack  in  1  from stack: ready to accept payload bytes
app_data_in_valid  out  1  payload byte strobe
app_data_in  out  8  payload byte
arp_req  out  1  one-cycle ARP request pulse
arp_found  in  1  ARP reply received
mac_not_exist  in  1  destination MAC not cached
mac_send_end  in  1  stack finished transmitting a frame
busy  out  1  1 whenever state is not IDLE or DONE
done  out  1  level; 1 in DONE (burst complete)
arp_fail  out  1  sticky; set on ARP exhaustion, cleared by rst or on leaving IDLE
pkt_cnt  out  32  packets sent since reset; also the next sequence number

Behaviour:
Reset: all outputs 0; seq/pkt_cnt 0; LFSR = LFSR_SEED; state IDLE. Reset mid-packet aborts immediately; no further bytes are driven.

States: IDLE, ARP_REQ, ARP_SEND, ARP_WAIT, CHECK_ARP, GEN_REQ, WRITE, SEND_WAIT, GAP, DONE.
- IDLE: cfg_enable=1 -> ARP_REQ; clear run counter, retry counter and arp_fail.
- ARP_REQ: arp_req=1 for exactly this cycle; increment retry counter -> ARP_SEND.
- ARP_SEND: mac_send_end -> ARP_WAIT.
- ARP_WAIT: counter runs from 0.
  - arp_found -> CHECK_ARP; arp_found wins if it coincides with timeout.
  - Counter == ARP_RETRY_CNT-1: if retries == ARP_MAX_RETRY, set arp_fail -> IDLE; else -> ARP_REQ.
- CHECK_ARP:
  - cfg_enable=0 -> IDLE.
  - mac_not_exist=1 -> ARP_REQ, retry counter cleared first.
  - Otherwise -> GEN_REQ; latch len = clamp(cfg_len, 1, MAX_LEN), mode, fill; reseed LFSR.
- GEN_REQ: app_data_request=1 (level), app_data_length=len. udp_send_ack sampled high -> WRITE. No timeout.
- WRITE: app_data_in_valid=1 for exactly len consecutive cycles, first byte the cycle after the ack is sampled, then -> SEND_WAIT.
  - Byte k (0-based): k<4 -> seq[31-8k -: 8] (big-endian; truncated if len<4).
  - k>=4, mode 0 -> (k-4) mod 256.
  - k>=4, mode 1 -> cfg_fill latched.
  - k>=4, mode 2 -> current LFSR, then advance: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - app_data_in = 0 when valid=0.
- SEND_WAIT: mac_send_end -> seq/pkt_cnt += 1 (wraps 2^32-1 -> 0), run counter += 1 -> GAP.
- GAP: counter 0..GAP_CNT-1, then:
  - cfg_enable=0 -> IDLE.
  - cfg_pkt_num!=0 and run counter == cfg_pkt_num -> DONE.
  - Otherwise -> CHECK_ARP.
- DONE: done=1; cfg_enable=0 -> IDLE.

Other rules:
- cfg_* changes mid-packet have no effect until the next CHECK_ARP.
- cfg_enable drop during any ARP or packet state does not abort; it is honoured at CHECK_ARP or end of GAP.
- Counters are 32-bit; no combinational path from inputs to outputs.

Test Plan:
1. GAP_CNT=16, ARP_RETRY_CNT=32. Enable, arp_found 10 cycles after ARP mac_send_end, mode 0, len 8, pkt_num 2 -> exactly 1 arp_req pulse; 2 packets with bytes 00 00 00 00 00 01 02 03 then 00 00 00 01 00 01 02 03; done=1; pkt_cnt=2.
2. Mode 2, len 6, seed FF -> payload seq bytes, then FF, FE; LFSR identical at the start of every packet.
3. Never assert arp_found, ARP_MAX_RETRY=3 -> 3 arp_req pulses 32+ cycles apart; arp_fail=1; state IDLE; busy=0.
4. cfg_len=0 and cfg_len=2000 with MAX_LEN=1472 -> app_data_length 1 and 1472; valid-high counts 1 and 1472. len=1 payload is seq[31:24] only.
5. mac_not_exist=1 at CHECK_ARP -> new arp_req before the next app_data_request; packet follows after arp_found.
6. Assert rst during WRITE at byte 5 -> same edge valid=0 and all outputs 0; after release with enable=1, restarts from ARP with seq=0.
